// File: rtl/dsm_array.sv
// dsm_array: multi-channel 1-bit delta-sigma modulator.
// Each channel turns an unsigned WIDTH-bit level into a pulse-density stream.
// The order is selected at run time and shared by all channels:
// first order (accumulator carry) or second order (two saturating integrators).
// A shared divider sets the update rate. Per-channel hold registers are
// written by a load strobe. Each channel has a sticky saturation flag.
module dsm_array #(
    parameter int WIDTH     = 20,
    parameter int NUM_CH    = 1,
    parameter int RATE_DIV  = 1,
    parameter int INT_GUARD = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    order_sel,
    input  logic                    vin_load,
    input  logic [NUM_CH*WIDTH-1:0] vin,
    input  logic                    ovf_clr,
    output logic                    update,
    output logic [NUM_CH-1:0]       pwm,
    output logic [NUM_CH-1:0]       ovf
);

    // Integrator width, and a wider working width so sums never wrap before clamping
    localparam int IW = WIDTH + INT_GUARD + 1;
    localparam int SW = IW + 2;
    localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(RATE_DIV - 1);
    localparam logic signed [SW-1:0] FB_FULL = {{(SW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};
    localparam logic signed [SW-1:0] INT_MAX = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] INT_MIN = {3'b111, {(IW-1){1'b0}}};

    logic [CW-1:0]          div_cnt;
    logic                   order_q;
    logic                   order_chg;
    logic                   div_wrap;
    logic                   step;

    logic [WIDTH-1:0]       hold [NUM_CH];
    logic [WIDTH-1:0]       acc  [NUM_CH];
    logic signed [IW-1:0]   i1   [NUM_CH];
    logic signed [IW-1:0]   i2   [NUM_CH];

    logic [WIDTH:0]         fo_sum [NUM_CH];
    logic signed [SW-1:0]   fb_val [NUM_CH];
    logic signed [SW-1:0]   raw1   [NUM_CH];
    logic signed [SW-1:0]   raw2   [NUM_CH];
    logic signed [IW-1:0]   i1_nxt [NUM_CH];
    logic signed [IW-1:0]   i2_nxt [NUM_CH];
    logic [NUM_CH-1:0]      y_bit;
    logic [NUM_CH-1:0]      ovf_set;

    function automatic logic signed [SW-1:0] sext(input logic signed [IW-1:0] v);
        return {{(SW-IW){v[IW-1]}}, v};
    endfunction

    function automatic logic out_of_range(input logic signed [SW-1:0] v);
        return (v > INT_MAX) || (v < INT_MIN);
    endfunction

    function automatic logic signed [IW-1:0] clamp_iw(input logic signed [SW-1:0] v);
        logic signed [IW-1:0] r;
        if (v > INT_MAX) begin
            r = INT_MAX[IW-1:0];
        end else if (v < INT_MIN) begin
            r = INT_MIN[IW-1:0];
        end else begin
            r = v[IW-1:0];
        end
        return r;
    endfunction

    // A change of order is detected against the registered copy. It spends one edge
    // clearing the modulator state, and that edge produces no update.
    assign order_chg = (order_sel != order_q);
    assign div_wrap  = (div_cnt == DIV_LAST);
    assign step      = en & div_wrap & ~order_chg;
    assign update    = reset & step;

    // Rate divider: free-runs while enabled, frozen otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        end
    end

    // Registered copy of the order select, advanced only while running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            order_q <= 1'b0;
        end else if (en) begin
            order_q <= order_sel;
        end
    end

    // Per-channel level hold registers, written by the load strobe even when stopped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hold[k] <= '0;
            end
        end else if (vin_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                hold[k] <= vin[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state arithmetic for both modulator orders, with saturation detection
    always_comb begin
        y_bit   = '0;
        ovf_set = '0;
        fo_sum  = '{default: '0};
        fb_val  = '{default: '0};
        raw1    = '{default: '0};
        raw2    = '{default: '0};
        i1_nxt  = '{default: '0};
        i2_nxt  = '{default: '0};
        for (int k = 0; k < NUM_CH; k++) begin
            fo_sum[k]  = {1'b0, acc[k]} + {1'b0, hold[k]};
            y_bit[k]   = ~i2[k][IW-1];
            fb_val[k]  = y_bit[k] ? FB_FULL : '0;
            raw1[k]    = sext(i1[k]) + $signed({{(SW-WIDTH){1'b0}}, hold[k]}) - fb_val[k];
            i1_nxt[k]  = clamp_iw(raw1[k]);
            raw2[k]    = sext(i2[k]) + sext(i1_nxt[k]) - fb_val[k];
            i2_nxt[k]  = clamp_iw(raw2[k]);
            ovf_set[k] = step & order_sel & (out_of_range(raw1[k]) | out_of_range(raw2[k]));
        end
    end

    // Modulator state and outputs: cleared on an order change, advanced on update edges
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
                i1[k]  <= '0;
                i2[k]  <= '0;
            end
            pwm <= '0;
        end else if (en && order_chg) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
                i1[k]  <= '0;
                i2[k]  <= '0;
            end
        end else if (step) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (order_sel) begin
                    i1[k]  <= i1_nxt[k];
                    i2[k]  <= i2_nxt[k];
                    pwm[k] <= y_bit[k];
                end else begin
                    acc[k] <= fo_sum[k][WIDTH-1:0];
                    pwm[k] <= fo_sum[k][WIDTH];
                end
            end
        end
    end

    // Sticky overflow flags; a new saturation wins over a simultaneous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_set;
        end
    end

endmodule

// File: tb/tb_dsm_array.sv
// tb_dsm_array: bench for dsm_array, using two instances on shared stimulus.
// Instance a: one channel, update every clock.
// Instance b: three channels, update every 4th clock.
// A behavioural integer model predicts each update's pwm/ovf into a queue per
// instance. Monitors pop and compare whenever an instance signals an update.
module tb_dsm_array;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        order_sel = 1'b0;
    logic        vin_load = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [23:0] vin = '0;

    logic        update_a, update_b;
    logic [0:0]  pwm_a, ovf_a;
    logic [2:0]  pwm_b, ovf_b;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0] pwm;
        logic [2:0] ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state, index 0 = instance a, 1 = instance b
    int         m_hold [2][3];
    int         m_acc  [2][3];
    int         m_i1   [2][3];
    int         m_i2   [2][3];
    int         m_cnt  [2];
    logic       m_oq   [2];
    logic [2:0] m_pwm  [2];
    logic [2:0] m_ovf  [2];

    int   ones_a, upd_a, upd_b;
    int   ones_b [3];
    logic last_pre_a, last_pre_b;
    logic pend_a = 1'b0, pend_b = 1'b0;
    exp_t e_a, e_b;

    dsm_array #(.WIDTH(8), .NUM_CH(1), .RATE_DIV(1), .INT_GUARD(4)) dut_a (
        .clock(clock), .reset(reset), .en(en), .order_sel(order_sel),
        .vin_load(vin_load), .vin(vin[7:0]), .ovf_clr(ovf_clr),
        .update(update_a), .pwm(pwm_a), .ovf(ovf_a)
    );

    dsm_array #(.WIDTH(8), .NUM_CH(3), .RATE_DIV(4), .INT_GUARD(4)) dut_b (
        .clock(clock), .reset(reset), .en(en), .order_sel(order_sel),
        .vin_load(vin_load), .vin(vin), .ovf_clr(ovf_clr),
        .update(update_b), .pwm(pwm_b), .ovf(ovf_b)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests_run++;
        if (act < lo || act > hi) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Integrator range for WIDTH=8, INT_GUARD=4: 13-bit signed
    function automatic int clampi(input int v, output bit hit);
        hit = (v > 4095) || (v < -4096);
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                m_hold[d][c] = 0;
                m_acc[d][c]  = 0;
                m_i1[d][c]   = 0;
                m_i2[d][c]   = 0;
            end
            m_cnt[d] = 0;
            m_oq[d]  = 1'b0;
            m_pwm[d] = '0;
            m_ovf[d] = '0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    // One clock edge of the model, from the inputs currently driven
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int rate, nch, s, x, a, b, fb;
            bit chg, upd, h1, h2, y;
            logic [2:0] set_v;
            exp_t e;
            rate = (d == 0) ? 1 : 4;
            nch  = (d == 0) ? 1 : 3;
            chg  = en && (order_sel != m_oq[d]);
            upd  = en && !chg && (m_cnt[d] == rate - 1);
            if (en) m_cnt[d] = (m_cnt[d] == rate - 1) ? 0 : m_cnt[d] + 1;
            if (chg) begin
                m_oq[d] = order_sel;
                for (int c = 0; c < 3; c++) begin
                    m_acc[d][c] = 0;
                    m_i1[d][c]  = 0;
                    m_i2[d][c]  = 0;
                end
            end
            set_v = '0;
            if (upd) begin
                for (int c = 0; c < nch; c++) begin
                    x = m_hold[d][c];
                    if (!order_sel) begin
                        s = m_acc[d][c] + x;
                        m_pwm[d][c] = (s >= 256);
                        m_acc[d][c] = s % 256;
                    end else begin
                        y  = (m_i2[d][c] >= 0);
                        fb = y ? 256 : 0;
                        a  = clampi(m_i1[d][c] + x - fb, h1);
                        b  = clampi(m_i2[d][c] + a - fb, h2);
                        m_i1[d][c]  = a;
                        m_i2[d][c]  = b;
                        m_pwm[d][c] = y;
                        if (h1 || h2) set_v[c] = 1'b1;
                    end
                end
            end
            m_ovf[d] = (ovf_clr ? 3'b000 : m_ovf[d]) | set_v;
            if (vin_load) begin
                for (int c = 0; c < nch; c++) m_hold[d][c] = int'(vin[c*8 +: 8]);
            end
            if (upd) begin
                e.pwm = m_pwm[d];
                e.ovf = m_ovf[d];
                if (d == 0) q_a.push_back(e);
                else        q_b.push_back(e);
            end
        end
    endtask

    task automatic clear_counts();
        ones_a = 0; upd_a = 0; upd_b = 0;
        for (int c = 0; c < 3; c++) ones_b[c] = 0;
    endtask

    // Advance one clock: predict, sample update before the edge, tally after it
    task automatic tick();
        logic pre_a, pre_b;
        model_edge();
        #2;
        pre_a = update_a;
        pre_b = update_b;
        @(posedge clock);
        #1;
        last_pre_a = pre_a;
        last_pre_b = pre_b;
        if (pre_a) begin
            upd_a++;
            ones_a += int'(pwm_a);
        end
        if (pre_b) begin
            upd_b++;
            for (int c = 0; c < 3; c++) ones_b[c] += int'(pwm_b[c]);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check_val("rst_pwm", {pwm_a, pwm_b}, 0);
        check_val("rst_ovf", {ovf_a, ovf_b}, 0);
        check_val("rst_update", {update_a, update_b}, 0);
        model_reset();
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
    endtask

    // Scoreboard monitor: compare the outputs right after each update edge
    always @(negedge clock) begin
        if (!reset) begin
            pend_a = 1'b0;
            pend_b = 1'b0;
        end else begin
            if (pend_a) begin
                check_val("sb_a_expected", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    e_a = q_a.pop_front();
                    check_val("sb_a_pwm", pwm_a, e_a.pwm[0]);
                    check_val("sb_a_ovf", ovf_a, e_a.ovf[0]);
                end
            end
            if (pend_b) begin
                check_val("sb_b_expected", q_b.size() > 0, 1);
                if (q_b.size() > 0) begin
                    e_b = q_b.pop_front();
                    check_val("sb_b_pwm", pwm_b, e_b.pwm);
                    check_val("sb_b_ovf", ovf_b, e_b.ovf);
                end
            end
            pend_a = update_a;
            pend_b = update_b;
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        logic [7:0]  pat;
        logic [11:0] spat;
        logic [0:0]  pa;
        logic [2:0]  pb;
        int          hit_at;

        #3;
        apply_reset();

        // First order, x=64: 0,0,0,1 repeating, 64 ones per 256 updates
        vin = {8'd224, 8'd128, 8'd64};
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        en = 1'b1;
        clear_counts();
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat[i] = pwm_a[0];
        end
        check_val("fo_x64_pattern", pat, 8'b1000_1000);
        repeat (248) tick();
        check_val("fo_x64_updates", upd_a, 256);
        check_val("fo_x64_ones", ones_a, 64);
        check_val("div4_update_count", upd_b, 64);

        // First order, x=0 and x=255
        vin = {8'd224, 8'd128, 8'd0};
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        clear_counts();
        repeat (256) tick();
        check_val("fo_x0_ones", ones_a, 0);
        vin = {8'd224, 8'd128, 8'd255};
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        clear_counts();
        repeat (256) tick();
        check_val("fo_x255_ones", ones_a, 255);

        // Divider spacing, then a 10-clock freeze
        spat = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            spat[i] = last_pre_b;
        end
        check_val("div4_spacing", (spat[3:0] == spat[7:4]) && (spat[7:4] == spat[11:8])
                  && ($countones(spat[3:0]) == 1), 1);
        pa = pwm_a;
        pb = pwm_b;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("freeze_hold", {last_pre_a, last_pre_b, pwm_a, pwm_b}, {2'b00, pa, pb});
        end
        en = 1'b1;
        repeat (40) tick();

        // Second order, x=128: half density, no saturation
        order_sel = 1'b1;
        vin = {8'd128, 8'd128, 8'd128};
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        clear_counts();
        repeat (1024) tick();
        check_val("so_x128_updates", upd_a, 1024);
        check_range("so_x128_ones_a", ones_a, 510, 514);
        check_range("so_x128_ones_b1", ones_b[1], 126, 130);
        check_val("so_x128_ovf", {ovf_a, ovf_b}, 0);

        // Second order, x=255 from cleared integrators: saturates, flags stick
        order_sel = 1'b0; tick();
        order_sel = 1'b1;
        vin = {8'd255, 8'd255, 8'd255};
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        clear_counts();
        hit_at = -1;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (hit_at < 0 && ovf_a[0]) hit_at = upd_a;
        end
        check_range("so_x255_ovf_a_within", hit_at, 1, 32);
        check_val("so_x255_ovf_b", ovf_b, 3'b111);

        // Back to a stable level, clear integrators, then clear the flags
        vin = {8'd128, 8'd128, 8'd128};
        order_sel = 1'b0;
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        order_sel = 1'b1; tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check_val("ovf_clr_now", {ovf_a, ovf_b}, 0);
        repeat (200) tick();
        check_val("ovf_clr_stays", {ovf_a, ovf_b}, 0);

        // Drive saturation again, then reset in the middle of the stream
        vin = {8'd255, 8'd255, 8'd255};
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        repeat (200) tick();
        check_val("pre_reset_ovf_a", ovf_a, 1);
        order_sel = 1'b0;
        apply_reset();

        // Three channels at 1/8, 1/2, 7/8 in first order, then switch to second order
        vin = {8'd224, 8'd128, 8'd32};
        en = 1'b0;
        vin_load = 1'b1; tick(); vin_load = 1'b0;
        en = 1'b1;
        clear_counts();
        repeat (1024) tick();
        check_val("fo3_updates", upd_b, 256);
        check_val("fo3_ones0", ones_b[0], 32);
        check_val("fo3_ones1", ones_b[1], 128);
        check_val("fo3_ones2", ones_b[2], 224);
        check_val("fo3_ones_a", ones_a, 128);
        order_sel = 1'b1; tick();
        clear_counts();
        repeat (1024) tick();
        check_range("so3_ones0", ones_b[0], 28, 36);
        check_range("so3_ones1", ones_b[1], 124, 132);
        check_range("so3_ones2", ones_b[2], 220, 228);
        check_val("so3_ovf", ovf_b, 0);
        order_sel = 1'b0; tick();
        repeat (200) tick();

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            vin_load = ($urandom_range(0, 15) == 0);
            if (vin_load) vin = 24'($urandom());
            ovf_clr  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 63) == 0) order_sel = ~order_sel;
            tick();
        end

        // Drain and finish
        en = 1'b0; vin_load = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        check_val("sb_a_drained", q_a.size(), 0);
        check_val("sb_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
